// File: rtl/pacman_pkg.sv
// Shared types and helpers for the player and ghost motion controllers.
// The heading encoding doubles as the bit index into the packed wall-flag vector.
package pacman_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PROBE  = 2'd1,
    DECIDE = 2'd2,
    MOVE   = 2'd3
  } motion_state_t;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;

  typedef struct packed {
    logic valid;
    dir_t dir;
  } key_req_t;

  function automatic key_req_t decode_key(input logic [7:0] key);
    key_req_t r;
    r.valid = 1'b1;
    r.dir   = DIR_LEFT;
    case (key)
      KEY_W:   r.dir = DIR_UP;
      KEY_S:   r.dir = DIR_DOWN;
      KEY_A:   r.dir = DIR_LEFT;
      KEY_D:   r.dir = DIR_RIGHT;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

  // walls is packed {right, left, down, up}, matching dir_t values.
  function automatic logic wall_at(input dir_t d, input logic [3:0] walls);
    return walls[d];
  endfunction

endpackage

// File: rtl/frame_edge_detect.sv
// Brings the vertical-sync frame clock into the Clk domain and emits a
// single registered pulse per rising edge (3 Clk cycles after the edge).
module frame_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic tick
);

  logic sync1_q, sync2_q, hist_q, tick_q;
  logic tick_d;

  always_comb tick_d = sync2_q & ~hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= async_in;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/pacman_motion.sv
// Per-frame player motion: waits for wall probes to settle, then turns,
// continues or stops, and steps the sprite once; early turn keys are buffered.
module pacman_motion
  import pacman_pkg::*;
#(
  parameter logic [9:0] X_START    = 10'd320,
  parameter logic [9:0] Y_START    = 10'd240,
  parameter logic [9:0] X_MIN      = 10'd0,
  parameter logic [9:0] X_MAX      = 10'd639,
  parameter logic [9:0] Y_MIN      = 10'd0,
  parameter logic [9:0] Y_MAX      = 10'd479,
  parameter logic [9:0] STEP       = 10'd1,
  parameter logic [9:0] SIZE       = 10'd4,
  parameter int         PROBE_WAIT = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       UpWall,
  input  logic       DownWall,
  input  logic       LeftWall,
  input  logic       RightWall,
  output logic [9:0] ObjectX,
  output logic [9:0] ObjectY,
  output logic [9:0] ObjectS,
  output logic [1:0] Dir,
  output logic       Moving,
  output logic       frame_tick
);

  localparam int                CNT_W    = (PROBE_WAIT > 1) ? $clog2(PROBE_WAIT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PROBE_WAIT - 1);

  motion_state_t    state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [9:0]       x_q, x_d, y_q, y_d;
  dir_t             dir_q, dir_d, pend_dir_q, pend_dir_d;
  logic             pend_valid_q, pend_valid_d;
  logic             moving_q, moving_d;
  logic             tick;
  logic [3:0]       walls;
  key_req_t         key;
  logic             turn_ok, cont_ok;

  frame_edge_detect u_frame_edge (
    .clk      (Clk),
    .rst      (Reset),
    .async_in (frame_clk),
    .tick     (tick)
  );

  always_comb begin
    walls   = {RightWall, LeftWall, DownWall, UpWall};
    key     = decode_key(keycode);
    turn_ok = pend_valid_q && !wall_at(pend_dir_q, walls);
    cont_ok = !wall_at(dir_q, walls);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      x_q          <= X_START;
      y_q          <= Y_START;
      dir_q        <= DIR_LEFT;
      pend_dir_q   <= DIR_LEFT;
      pend_valid_q <= 1'b0;
      moving_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      dir_q        <= dir_d;
      pend_dir_q   <= pend_dir_d;
      pend_valid_q <= pend_valid_d;
      moving_q     <= moving_d;
    end
  end

  // Ticks arriving outside IDLE are simply ignored, capping motion at one step per frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (tick) state_d = PROBE;
      PROBE:   if (wait_cnt_q == CNT_LAST) state_d = DECIDE;
      DECIDE:  state_d = (turn_ok || cont_ok) ? MOVE : IDLE;
      MOVE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wait_cnt_d   = wait_cnt_q;
    x_d          = x_q;
    y_d          = y_q;
    dir_d        = dir_q;
    pend_dir_d   = pend_dir_q;
    pend_valid_d = pend_valid_q;
    moving_d     = moving_q;
    unique case (state_q)
      IDLE:  wait_cnt_d = '0;
      PROBE: wait_cnt_d = wait_cnt_q + 1'b1;
      DECIDE: begin
        if (turn_ok) begin
          dir_d        = pend_dir_q;
          pend_valid_d = 1'b0;
        end else if (!cont_ok) begin
          moving_d = 1'b0;
        end
      end
      MOVE: begin
        moving_d = 1'b1;
        unique case (dir_q)
          DIR_LEFT:  x_d = (x_q < X_MIN + STEP) ? X_MAX : x_q - STEP;
          DIR_RIGHT: x_d = (x_q > X_MAX - STEP) ? X_MIN : x_q + STEP;
          DIR_UP:    y_d = (y_q < Y_MIN + STEP) ? Y_MIN : y_q - STEP;
          DIR_DOWN:  y_d = (y_q > Y_MAX - STEP) ? Y_MAX : y_q + STEP;
          default:   x_d = x_q;
        endcase
      end
      default: wait_cnt_d = '0;
    endcase
    // A key seen in the DECIDE cycle outranks the clear above and waits for next frame.
    if (key.valid) begin
      pend_dir_d   = key.dir;
      pend_valid_d = 1'b1;
    end
  end

  assign ObjectX = x_q;
  assign ObjectY = y_q;
  assign ObjectS = SIZE;
  assign Dir     = dir_q;
  assign Moving  = moving_q;
  assign frame_tick = tick;

endmodule

// File: tb/tb_pacman_motion.sv
// Randomized bench for pacman_motion against a frame-level behavioural model.
module tb_pacman_motion;
  import pacman_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset, frame_clk;
  logic [7:0] keycode;
  logic       UpWall, DownWall, LeftWall, RightWall;
  logic [9:0] ObjectX, ObjectY, ObjectS;
  logic [1:0] Dir;
  logic       Moving, frame_tick;

  pacman_motion dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
    .UpWall(UpWall), .DownWall(DownWall), .LeftWall(LeftWall), .RightWall(RightWall),
    .ObjectX(ObjectX), .ObjectY(ObjectY), .ObjectS(ObjectS),
    .Dir(Dir), .Moving(Moving), .frame_tick(frame_tick)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0, n_err = 0;
  int n_ticks = 0, exp_ticks = 0;
  int mx, my, mdir, mmov, mpv, mpd;

  always @(negedge Clk) if (frame_tick) n_ticks++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mx = 320; my = 240; mdir = 2; mmov = 0; mpv = 0; mpd = 2;
  endtask

  task automatic model_key(input logic [7:0] k);
    case (k)
      8'h1A: begin mpd = 0; mpv = 1; end
      8'h16: begin mpd = 1; mpv = 1; end
      8'h04: begin mpd = 2; mpv = 1; end
      8'h07: begin mpd = 3; mpv = 1; end
      default: ;
    endcase
  endtask

  task automatic model_step();
    mmov = 1;
    case (mdir)
      0: my = (my > 0) ? my - 1 : 0;
      1: my = (my < 479) ? my + 1 : 479;
      2: mx = (mx == 0) ? 639 : mx - 1;
      default: mx = (mx == 639) ? 0 : mx + 1;
    endcase
  endtask

  // walls bit order: 0 up, 1 down, 2 left, 3 right
  task automatic model_frame(input logic [3:0] walls);
    if (mpv != 0 && !walls[mpd]) begin
      mdir = mpd; mpv = 0; model_step();
    end else if (!walls[mdir]) begin
      model_step();
    end else begin
      mmov = 0;
    end
  endtask

  task automatic check_state();
    chk("ObjectX", 32'(ObjectX), 32'(mx));
    chk("ObjectY", 32'(ObjectY), 32'(my));
    chk("Dir", 32'(Dir), 32'(mdir));
    chk("Moving", 32'(Moving), 32'(mmov));
    chk("pend_valid", 32'(dut.pend_valid_q), 32'(mpv));
  endtask

  task automatic press(input logic [7:0] k);
    @(negedge Clk) keycode = k;
    @(negedge Clk) keycode = 8'h00;
    model_key(k);
  endtask

  task automatic frame(input logic [3:0] walls);
    int lat;
    bit got;
    {RightWall, LeftWall, DownWall, UpWall} = walls;
    @(posedge Clk); #2 frame_clk = 1'b1;
    lat = 0; got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge Clk);
      if (frame_tick) got = 1; else lat++;
    end
    chk("tick_latency", 32'(lat), 32'd3);
    @(negedge Clk);
    chk("tick_width", 32'(frame_tick), 32'd0);
    frame_clk = 1'b0;
    exp_ticks++;
    repeat (8) @(negedge Clk);
    model_frame(walls);
    check_state();
  endtask

  initial begin
    logic [7:0] keys [6];
    int guard;
    keys[0] = 8'h1A; keys[1] = 8'h16; keys[2] = 8'h04;
    keys[3] = 8'h07; keys[4] = 8'h00; keys[5] = 8'h55;
    Reset = 1'b1; frame_clk = 1'b0; keycode = 8'h00;
    {RightWall, LeftWall, DownWall, UpWall} = 4'b0000;
    model_reset();
    repeat (3) @(negedge Clk);
    chk("rst_ObjectS", 32'(ObjectS), 32'd4);
    chk("rst_tick", 32'(frame_tick), 32'd0);
    check_state();
    Reset = 1'b0;

    repeat (3) frame(4'b0000);
    chk("x_after3", 32'(ObjectX), 32'd317);

    press(8'h1A);
    frame(4'b0001);
    frame(4'b0001);
    frame(4'b0000);
    chk("turn_up_y", 32'(ObjectY), 32'd239);

    press(8'h04);
    frame(4'b0000);
    frame(4'b0100);
    chk("stop_moving", 32'(Moving), 32'd0);
    frame(4'b0000);

    guard = 0;
    while (mx != 0 && guard < 700) begin frame(4'b0000); guard++; end
    chk("reach_x0", 32'(ObjectX), 32'd0);
    frame(4'b0000);
    chk("wrap_left", 32'(ObjectX), 32'd639);
    press(8'h07);
    frame(4'b0000);
    chk("wrap_right", 32'(ObjectX), 32'd0);

    press(8'h1A);
    guard = 0;
    while (my != 0 && guard < 300) begin frame(4'b0000); guard++; end
    frame(4'b0000);
    chk("clamp_top_y", 32'(ObjectY), 32'd0);
    chk("clamp_top_mv", 32'(Moving), 32'd1);
    press(8'h16);
    guard = 0;
    while (my != 479 && guard < 500) begin frame(4'b0000); guard++; end
    frame(4'b0000);
    chk("clamp_bot_y", 32'(ObjectY), 32'd479);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 1) == 1) press(keys[$urandom_range(0, 5)]);
      frame(4'($urandom & $urandom));
    end

    // two rising edges 2 Clk apart yield a single step
    {RightWall, LeftWall, DownWall, UpWall} = 4'b0000;
    @(posedge Clk); #2 frame_clk = 1'b1;
    @(posedge Clk); #2 frame_clk = 1'b0;
    @(posedge Clk); #2 frame_clk = 1'b1;
    @(posedge Clk); #2 frame_clk = 1'b0;
    repeat (15) @(negedge Clk);
    exp_ticks += 2;
    model_frame(4'b0000);
    check_state();

    press(8'h04);
    guard = 0;
    while (mx != 300 && guard < 700) begin frame(4'b0000); guard++; end
    chk("reach_x300", 32'(ObjectX), 32'd300);
    @(posedge Clk); #2 frame_clk = 1'b1;
    repeat (4) @(posedge Clk);
    #1 chk("in_probe", 32'(dut.state_q), 32'(PROBE));
    #1 Reset = 1'b1; frame_clk = 1'b0;
    exp_ticks++;
    model_reset();
    #1;
    check_state();
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    @(negedge Clk) Reset = 1'b0;
    repeat (20) @(negedge Clk);
    chk("no_step_x", 32'(ObjectX), 32'd320);
    chk("no_step_mv", 32'(Moving), 32'd0);
    frame(4'b0000);
    chk("post_rst_x", 32'(ObjectX), 32'd319);

    chk("tick_count", 32'(n_ticks), 32'(exp_ticks));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
